// File: rtl/enemy_fire_sched.sv
// ---------------------------------------------------------------------------
// enemy_fire_sched
//
// Decides which enemy tank fires next. Each tank has a cooldown counter that
// starts when its previous bullet dies. Eligible tanks are served in
// round-robin order. Shots are spaced at least three frames apart, and the
// total number of live enemy bullets is capped by holding the scheduler. An
// optional 16-bit LFSR can randomly skip frames so that firing is less
// predictable.
//
// Ports
//   clk_f          in   1   frame-rate clock (sole clock)
//   rst_n          in   1   asynchronous active-low reset
//   enable         in   1   game running
//   tank_exit      in   5   per-tank alive flags, bit i = tank i
//   bullet_exit    in   5   per-tank bullet-alive flags from the bullet blocks
//   shoot          out  5   one-hot, single-cycle fire pulse to bullet block i
//   bullet_counter out 30   6-bit cooldown counter per tank, tank i at [6*i+:6]
//   live_count     out  3   registered popcount of bullet_exit
//   state          out  2   00 IDLE, 01 RUN, 10 HOLD
// ---------------------------------------------------------------------------
module enemy_fire_sched #(
    parameter int          COOLDOWN  = 60,
    parameter int          MAX_LIVE  = 3,
    parameter int          RANDOM_EN = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk_f,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [4:0]  tank_exit,
    input  logic [4:0]  bullet_exit,
    output logic [4:0]  shoot,
    output logic [29:0] bullet_counter,
    output logic [2:0]  live_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [5:0] COOLDOWN_W = 6'(COOLDOWN);
    localparam logic [2:0] MAX_LIVE_W = 3'(MAX_LIVE);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q [5];
    logic [2:0]  ptr_q;
    logic [1:0]  spacing_q;
    logic [15:0] lfsr_q;
    logic [4:0]  shoot_q;
    logic [2:0]  live_q;

    logic [4:0]  eligible;
    logic        found;
    logic [2:0]  grant_idx;
    logic        rand_ok;
    logic        grant;

    // ---------------- FSM: state register ----------------
    // NOTE: every sequential block assigns with <= so that all flops sample
    // pre-edge values; using = here would create order-dependent races.
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: the default assignment at the top of every always_comb keeps each
    // path fully assigned, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (!enable)                       state_d = ST_IDLE;
                else if (live_q >= MAX_LIVE_W)     state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!enable)                       state_d = ST_IDLE;
                else if (live_q < MAX_LIVE_W)      state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        state      = state_q;
        shoot      = shoot_q;
        live_count = live_q;
        bullet_counter = '0;
        for (int i = 0; i < 5; i++) begin
            bullet_counter[6*i +: 6] = cnt_q[i];
        end
    end

    // ---------------- eligibility and round-robin pick ----------------
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            eligible[i] = tank_exit[i] & ~bullet_exit[i] & (cnt_q[i] == COOLDOWN_W);
        end
    end

    // Search starts one past the last granted tank and wraps modulo 5.
    always_comb begin
        found     = 1'b0;
        grant_idx = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            int cand;
            cand = int'(ptr_q) + k;
            if (cand >= 5) cand = cand - 5;
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                grant_idx = 3'(cand);
            end
        end
    end

    assign rand_ok = (RANDOM_EN == 0) || (lfsr_q[1:0] != 2'b00);
    assign grant   = (state_q == ST_RUN) && (spacing_q == 2'd0) && found && rand_ok;

    // ---------------- grant bookkeeping ----------------
    // The fire pulse is gated with enable. If the game stops in the grant
    // cycle, the FSM lands in IDLE and the pulse must not escape.
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            shoot_q   <= '0;
            ptr_q     <= 3'd4;
            spacing_q <= 2'd0;
        end else begin
            shoot_q <= (grant && enable) ? (5'd1 << grant_idx) : 5'd0;
            if (grant) begin
                ptr_q     <= grant_idx;
                spacing_q <= 2'd2;
            end else if (spacing_q != 2'd0) begin
                spacing_q <= spacing_q - 2'd1;
            end
        end
    end

    // ---------------- cooldown counters ----------------
    // A counter restarts when its tank is idle, dead, has a bullet in flight,
    // or is firing this frame. Otherwise it saturates at COOLDOWN.
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (state_q == ST_IDLE || !tank_exit[i] || bullet_exit[i] || shoot_q[i])
                    cnt_q[i] <= '0;
                else if (cnt_q[i] != COOLDOWN_W)
                    cnt_q[i] <= cnt_q[i] + 6'd1;
            end
        end
    end

    // ---------------- LFSR and live bullet count ----------------
    // Fibonacci LFSR with taps 16,14,13,11, shifting toward bit 0.
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
            live_q <= '0;
        end else begin
            if (state_q != ST_IDLE)
                lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            live_q <= 3'($countones(bullet_exit));
        end
    end

endmodule

// File: tb/tb_enemy_fire_sched.sv
// ---------------------------------------------------------------------------
// Testbench for enemy_fire_sched. A deterministic instance (RANDOM_EN=0)
// covers directed scenarios. A random instance (RANDOM_EN=1) is compared
// against a small reference model of the scheduler and its LFSR.
// ---------------------------------------------------------------------------
module tb_enemy_fire_sched;

    logic        clk_f = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [4:0]  tank_exit, bullet_exit;
    logic [4:0]  shoot;
    logic [29:0] bullet_counter;
    logic [2:0]  live_count;
    logic [1:0]  state;

    logic [4:0]  tank_exit_r, bullet_exit_r;
    logic [4:0]  shoot_r;
    logic [29:0] bullet_counter_r;
    logic [2:0]  live_count_r;
    logic [1:0]  state_r;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_f = ~clk_f;

    enemy_fire_sched #(.COOLDOWN(60), .MAX_LIVE(3), .RANDOM_EN(0), .LFSR_SEED(16'hACE1)) u_dut (
        .clk_f          (clk_f),
        .rst_n          (rst_n),
        .enable         (enable),
        .tank_exit      (tank_exit),
        .bullet_exit    (bullet_exit),
        .shoot          (shoot),
        .bullet_counter (bullet_counter),
        .live_count     (live_count),
        .state          (state)
    );

    enemy_fire_sched #(.COOLDOWN(60), .MAX_LIVE(3), .RANDOM_EN(1), .LFSR_SEED(16'hACE1)) u_dut_rnd (
        .clk_f          (clk_f),
        .rst_n          (rst_n),
        .enable         (enable),
        .tank_exit      (tank_exit_r),
        .bullet_exit    (bullet_exit_r),
        .shoot          (shoot_r),
        .bullet_counter (bullet_counter_r),
        .live_count     (live_count_r),
        .state          (state_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one frame; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [5:0] cnt(input int i);
        return bullet_counter[6*i +: 6];
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        enable        = 1'b0;
        tank_exit     = '0;
        bullet_exit   = '0;
        tank_exit_r   = '0;
        bullet_exit_r = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0]  seen;
        logic [15:0] m_lfsr, n_lfsr;
        logic [5:0]  m_cnt, n_cnt;
        logic [1:0]  m_spc;
        logic        m_run, m_shoot, m_grant;
        int          model_shots, dut_shots;

        // ---------------- reset values ----------------
        do_reset();
        check("rst_state", state, 2'b00);
        check("rst_shoot", shoot, 5'b0);
        check("rst_counters", bullet_counter, 30'd0);
        check("rst_live", live_count, 3'd0);

        // ---------------- single tank cooldown ----------------
        enable    = 1'b1;
        tank_exit = 5'b00001;
        tick();
        check("single_run_state", state, 2'b01);
        check("single_cnt_start", cnt(0), 6'd0);
        ticks(59);
        check("single_cnt59", cnt(0), 6'd59);
        check("single_no_early_shot", shoot, 5'b0);
        tick();
        check("single_cnt60", cnt(0), 6'd60);
        check("single_shoot_pending", shoot, 5'b0);
        tick();
        check("single_shoot", shoot, 5'b00001);
        tick();
        check("single_shoot_one_cycle", shoot, 5'b0);
        check("single_cnt_cleared", cnt(0), 6'd0);

        // ---------------- five tanks round robin ----------------
        do_reset();
        enable    = 1'b1;
        tank_exit = 5'b11111;
        tick();
        ticks(60);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_shoot_%0d", i), shoot, 5'd1 << i);
            if (i < 4) begin
                tick();
                check("rr_gap_a", shoot, 5'b0);
                tick();
                check("rr_gap_b", shoot, 5'b0);
            end
        end
        seen = '0;
        for (int i = 0; i < 49; i++) begin
            tick();
            seen |= shoot;
        end
        check("rr_quiet_during_cooldown", seen, 5'b0);
        tick();
        check("rr_wrap_tank0", shoot, 5'b00001);

        // ---------------- live bullet cap and hold ----------------
        do_reset();
        enable      = 1'b1;
        tank_exit   = 5'b11111;
        bullet_exit = 5'b00111;
        tick();
        check("hold_live3", live_count, 3'd3);
        tick();
        check("hold_state", state, 2'b10);
        seen = '0;
        for (int i = 0; i < 70; i++) begin
            tick();
            seen |= shoot;
        end
        check("hold_no_shoot", seen, 5'b0);
        check("hold_still", state, 2'b10);
        check("hold_cnt3_ready", cnt(3), 6'd60);
        bullet_exit = 5'b00110;
        tick();
        check("hold_live2", live_count, 3'd2);
        tick();
        check("hold_back_to_run", state, 2'b01);
        tick();
        check("hold_shoot_tank3", shoot, 5'b01000);

        // ---------------- async reset mid-cycle with shoot pending ----------------
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_shoot", shoot, 5'b0);
        check("areset_state", state, 2'b00);
        check("areset_live", live_count, 3'd0);
        check("areset_counters", bullet_counter, 30'd0);

        // ---------------- tank death mid-cooldown ----------------
        do_reset();
        enable    = 1'b1;
        tank_exit = 5'b00100;
        tick();
        ticks(40);
        check("death_cnt40", cnt(2), 6'd40);
        tank_exit = 5'b00000;
        tick();
        check("death_cnt_cleared", cnt(2), 6'd0);
        tank_exit = 5'b00100;
        seen = '0;
        for (int i = 0; i < 59; i++) begin
            tick();
            seen |= shoot;
        end
        check("death_cnt59", cnt(2), 6'd59);
        check("death_no_early_shot", seen, 5'b0);
        tick();
        check("death_cnt60", cnt(2), 6'd60);
        tick();
        check("death_shoot", shoot, 5'b00100);

        // ---------------- enable drops in the grant cycle ----------------
        do_reset();
        enable    = 1'b1;
        tank_exit = 5'b00001;
        tick();
        ticks(60);
        check("disable_cnt60", cnt(0), 6'd60);
        enable = 1'b0;
        tick();
        check("disable_state_idle", state, 2'b00);
        check("disable_shoot_suppressed", shoot, 5'b0);

        // ---------------- random gating against reference model ----------------
        do_reset();
        enable      = 1'b1;
        tank_exit_r = 5'b00001;
        m_run   = 1'b0;
        m_lfsr  = 16'hACE1;
        m_cnt   = '0;
        m_spc   = '0;
        m_shoot = 1'b0;
        model_shots = 0;
        dut_shots   = 0;
        for (int c = 0; c < 1000; c++) begin
            m_grant = m_run && (m_spc == 2'd0) && (m_cnt == 6'd60) && (m_lfsr[1:0] != 2'b00);
            n_lfsr  = m_run ? {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]} : m_lfsr;
            n_cnt   = (!m_run || m_shoot) ? 6'd0 : ((m_cnt == 6'd60) ? 6'd60 : m_cnt + 6'd1);
            m_spc   = m_grant ? 2'd2 : ((m_spc != 2'd0) ? m_spc - 2'd1 : 2'd0);
            m_shoot = m_grant;
            m_cnt   = n_cnt;
            m_lfsr  = n_lfsr;
            m_run   = 1'b1;
            tick();
            check($sformatf("rnd_shoot_c%0d", c), shoot_r, m_shoot ? 5'b00001 : 5'b00000);
            if (m_shoot) model_shots++;
            if (shoot_r != 5'b0) dut_shots++;
        end
        check("rnd_shot_count", dut_shots, model_shots);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
